// File: rtl/lfc_pkg.sv
// rtl/lfc_pkg.sv - shared types and default constants for the LFC RAM responder
//
// Purpose : word type, per-bank FSM state encoding and default parameter
//           values used by lfc_ram_bank and lfc_ram_responder.
// Ports   : none (package).

package lfc_pkg;

    typedef logic [31:0] word_t;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        BUSY    = 2'd1,
        DONE    = 2'd2,
        RELEASE = 2'd3
    } bank_state_t;

    localparam int DEF_NUM_BANKS = 4;
    localparam int DEF_DEPTH     = 256;
    localparam int DEF_LATENCY   = 4;

    // Width of the BUSY down-counter; it must hold LATENCY-1.
    function automatic int cnt_width(input int latency);
        return (latency > 1) ? $clog2(latency) : 1;
    endfunction

endpackage

// File: rtl/lfc_ram_bank.sv
// rtl/lfc_ram_bank.sv - one independent RAM bank with fixed-latency access FSM
//
// Purpose : services one read or write per request handshake. A request is
//           latched in IDLE, waits LATENCY BUSY cycles, commits to the word
//           array on the BUSY->DONE edge, pulses complete once and then waits
//           in RELEASE until the requester drops both strobes.
// Ports   : clk, n_rst     - clock, synchronous active-low reset
//           ren, wen       - read / write request (wen wins if both high)
//           addr, store    - byte address and write data, sampled in IDLE only
//           data           - last committed word (read result or written word)
//           complete       - one-cycle completion pulse

module lfc_ram_bank
    import lfc_pkg::*;
#(
    parameter int DEPTH   = DEF_DEPTH,
    parameter int LATENCY = DEF_LATENCY
) (
    input  logic  clk,
    input  logic  n_rst,
    input  logic  ren,
    input  logic  wen,
    input  word_t addr,
    input  word_t store,
    output word_t data,
    output logic  complete
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = cnt_width(LATENCY);

    bank_state_t      state;
    logic [CNT_W-1:0] cnt;
    logic [IDX_W-1:0] lat_idx;
    word_t            lat_store;
    logic             lat_write;
    word_t            data_q;
    logic             complete_q;
    word_t            mem [DEPTH];

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state      <= IDLE;
            cnt        <= '0;
            lat_idx    <= '0;
            lat_store  <= '0;
            lat_write  <= 1'b0;
            data_q     <= '0;
            complete_q <= 1'b0;
            // Memory contents are part of the reset state; an aborted write
            // therefore can never leave a stale word behind.
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else begin
            complete_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (ren || wen) begin
                        // Byte offset and bits above the array are dropped,
                        // so addresses alias modulo DEPTH words.
                        lat_idx   <= addr[2 +: IDX_W];
                        lat_store <= store;
                        lat_write <= wen;
                        cnt       <= CNT_W'(LATENCY - 1);
                        state     <= BUSY;
                    end
                end
                BUSY: begin
                    if (cnt == '0) begin
                        if (lat_write) begin
                            mem[lat_idx] <= lat_store;
                            data_q       <= lat_store;
                        end else begin
                            data_q <= mem[lat_idx];
                        end
                        state <= DONE;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                DONE: begin
                    // complete is registered, so it is seen in the cycle
                    // after DONE, while the bank already sits in RELEASE.
                    complete_q <= 1'b1;
                    state      <= RELEASE;
                end
                RELEASE: begin
                    // A request still held from the finished access must be
                    // dropped before a new one can be accepted.
                    if (!ren && !wen) begin
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign data     = data_q;
    assign complete = complete_q;

endmodule

// File: rtl/lfc_ram_responder.sv
// rtl/lfc_ram_responder.sv - multi-bank fixed-latency RAM responder
//
// Purpose : NUM_BANKS fully independent lfc_ram_bank instances, one per cache
//           bank port; this level is wiring only.
// Ports   : clk, n_rst        - clock, synchronous active-low reset
//           ram_mem_REN/WEN   - per-bank read / write request
//           ram_mem_addr      - per-bank byte address
//           ram_mem_store     - per-bank write data
//           ram_mem_data      - per-bank response data
//           ram_mem_complete  - per-bank one-cycle completion pulse

module lfc_ram_responder
    import lfc_pkg::*;
#(
    parameter int NUM_BANKS = DEF_NUM_BANKS,
    parameter int DEPTH     = DEF_DEPTH,
    parameter int LATENCY   = DEF_LATENCY
) (
    input  logic                        clk,
    input  logic                        n_rst,
    input  logic [NUM_BANKS-1:0]        ram_mem_REN,
    input  logic [NUM_BANKS-1:0]        ram_mem_WEN,
    input  logic [NUM_BANKS-1:0][31:0]  ram_mem_addr,
    input  logic [NUM_BANKS-1:0][31:0]  ram_mem_store,
    output logic [NUM_BANKS-1:0][31:0]  ram_mem_data,
    output logic [NUM_BANKS-1:0]        ram_mem_complete
);

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        lfc_ram_bank #(
            .DEPTH   (DEPTH),
            .LATENCY (LATENCY)
        ) u_bank (
            .clk      (clk),
            .n_rst    (n_rst),
            .ren      (ram_mem_REN[b]),
            .wen      (ram_mem_WEN[b]),
            .addr     (ram_mem_addr[b]),
            .store    (ram_mem_store[b]),
            .data     (ram_mem_data[b]),
            .complete (ram_mem_complete[b])
        );
    end

endmodule

// File: doc/lfc_ram_responder.md
LFC_RAM_RESPONDER -- requirements
Module: lfc_ram_responder

Interface
REQ-001 SHALL have parameter NUM_BANKS, default 4, number of independent RAM banks (one per cache bank port).
REQ-002 SHALL have parameter DEPTH, default 256, 32-bit words per bank (power of two, >= 2).
REQ-003 SHALL have parameter LATENCY, default 4, BUSY cycles per access (>= 1).
REQ-004 SHALL have port clk  input  1  single clock, all state updates on rising edge.
REQ-005 SHALL have port n_rst  input  1  reset, synchronous, active-low.
REQ-006 SHALL have port ram_mem_REN  input  [NUM_BANKS-1:0]  per-bank read request.
REQ-007 SHALL have port ram_mem_WEN  input  [NUM_BANKS-1:0]  per-bank write request.
REQ-008 SHALL have port ram_mem_addr  input  [NUM_BANKS-1:0][31:0]  per-bank byte address.
REQ-009 SHALL have port ram_mem_store  input  [NUM_BANKS-1:0][31:0]  per-bank write data.
REQ-010 SHALL have port ram_mem_data  output  [NUM_BANKS-1:0][31:0]  per-bank response data.
REQ-011 SHALL have port ram_mem_complete  output  [NUM_BANKS-1:0]  per-bank one-cycle completion pulse.

Function
REQ-012 Each bank SHALL run an independent FSM: IDLE, BUSY, DONE, RELEASE. Banks share no state.
REQ-013 IDLE: if REN[b] or WEN[b] sampled high, latch addr, store, op; load counter with LATENCY-1; go BUSY. Else stay IDLE.
REQ-014 WEN SHALL take priority when REN and WEN are both high: treated as write.
REQ-015 BUSY: counter decrements each cycle; at counter == 0 go DONE. Inputs ignored throughout BUSY.
REQ-016 Request sampled at edge t -> complete[b] high exactly in cycle following edge t+LATENCY+1 (LATENCY BUSY cycles, then DONE).
REQ-017 Memory access SHALL commit on the BUSY->DONE edge: write stores latched data; read captures word into data register.
REQ-018 DONE: complete[b]=1 for exactly one cycle; then go RELEASE.
REQ-019 RELEASE: stay until REN[b] and WEN[b] both low, then IDLE. A held request SHALL NOT start a second access.
REQ-020 Word index = addr[2 +: log2(DEPTH)]; addr[1:0] and upper bits ignored (aliasing/wrap-around by design).
REQ-021 ram_mem_data[b] SHALL hold last captured value (read word, or written word for writes) from DONE until the next access commits.
REQ-022 Address/data changes by requester during BUSY SHALL have no effect (latched values used).
REQ-023 Read after write to same index SHALL return written value; same-index accesses on different banks are independent storage.

Reset
REQ-024 While n_rst low at a rising edge: all FSMs to IDLE, counters 0, complete 0, data registers 0, all memory words 0.
REQ-025 Reset during BUSY SHALL abort the access; no write commits; no complete pulse follows.
REQ-026 First request may be sampled on the first edge with n_rst high.

Structure
REQ-027 Shared package lfc_pkg SHALL hold word_t (32-bit), the bank-state enum (IDLE, BUSY, DONE, RELEASE) and default parameter constants.
REQ-028 SHALL instantiate sub-module lfc_ram_bank NUM_BANKS times via generate; each holds one FSM, counter, latches and DEPTH-word array.
REQ-029 Top level SHALL contain only generate/wiring logic.

Verification
REQ-030 Write then read, bank 0, LATENCY=4: WEN addr 0x10 store 0xDEADBEEF held until complete -> complete 5 cycles after sample; after RELEASE, REN addr 0x10 -> data 0xDEADBEEF with complete.
REQ-031 Held request: REN kept high 3 cycles past complete -> exactly one complete pulse, bank stays RELEASE until REN low.
REQ-032 Parallel banks: banks 0..3 write 0x1000+b to addr 0x0 in same cycle -> four simultaneous completes; reads return 0x1000..0x1003 per bank.
REQ-033 Aliasing/priority: DEPTH=256, write 0x55 to addr 0x0; REN+WEN at addr 0x400 store 0xAA -> treated as write; read addr 0x0 returns 0xAA.
REQ-034 Reset mid-op: WEN addr 0x20 store 0x1234, n_rst low 2nd BUSY cycle -> no complete; read addr 0x20 after reset returns 0x0.
REQ-035 Address change during BUSY: read addr 0x4 (holds 0x77), switch addr to 0x8 mid-BUSY -> data 0x77.
